mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter size, default 32: data and requester address width in bits.
REQ-002 Parameter MemAddrBits, default 9: memory address width (512 words).
REQ-003 Parameter MaxStreak, default 4: consecutive data grants allowed while fetch waits (fairness build only).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_req  input  1  fetch requester read request; held high until i_done.
REQ-007 i_addr  input  size  fetch word address; stable while i_req high.
REQ-008 i_gnt  output  1  fetch access issued this cycle.
REQ-009 i_done  output  1  fetch access complete; i_rdata valid this cycle.
REQ-010 i_rdata  output  size  fetch read data.
REQ-011 d_req  input  1  data requester request; held high until d_done.
REQ-012 d_we  input  1  1 = store, 0 = load; stable while d_req high.
REQ-013 d_addr  input  size  data word address; stable while d_req high.
REQ-014 d_wdata  input  size  store data; stable while d_req high.
REQ-015 d_gnt  output  1  data access issued this cycle.
REQ-016 d_done  output  1  data access complete; d_rdata valid this cycle when d_we=0.
REQ-017 d_rdata  output  size  load data.
REQ-018 mem_en  output  1  memory port enable.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  MemAddrBits  memory address; low MemAddrBits of the granted address.
REQ-021 mem_wdata  output  size  memory write data.
REQ-022 mem_rdata  input  size  memory read data, valid one cycle after the mem_en cycle.
REQ-023 busy  output  1  high in any state other than IDLE.

Function
REQ-024 FSM states IDLE, ACC, RESP; all outputs except i_rdata/d_rdata are registered decodes of state and owner.
REQ-025 IDLE: no request sampled -> stay IDLE; any request sampled -> ACC with owner latched.
REQ-026 ACC, exactly one cycle: mem_en=1; mem_addr/mem_wdata/mem_we taken from the owner; mem_we=1 only for a data store; the owner's gnt=1.
REQ-027 RESP, exactly one cycle: the owner's done=1; the owner's rdata = mem_rdata; next state always IDLE.
REQ-028 Requests sampled only in IDLE; a req still high during its own RESP cycle does not start a new access.
REQ-029 Outside RESP, i_rdata/d_rdata hold the last value captured at the end of that requester's RESP; store responses do not update d_rdata.
REQ-030 Access latency is request sampled at edge N -> gnt in cycle N+1 -> done in cycle N+2; minimum repeat period is 3 cycles.
REQ-031 Both requests pending in IDLE: data wins, except as modified by REQ-037.
REQ-032 i_gnt and d_gnt never both high; i_done and d_done never both high; at most one mem_en cycle per access.
REQ-033 Addresses wrap modulo 2^MemAddrBits; upper bits are ignored and no error is flagged.

Reset
REQ-034 reset low asynchronously forces state IDLE and all outputs 0, including i_rdata, d_rdata, mem_addr, mem_wdata and the streak counter.
REQ-035 Reset asserted during ACC or RESP abandons the access: no done is issued and requesters must re-request.
REQ-036 After reset deasserts, the first rising edge with a request present samples it as in REQ-025.

Configuration
REQ-037 MEM_ARB_FAIRNESS_EN defined: a streak counter increments (saturating at MaxStreak) on each data grant while i_req is high and clears on each fetch grant; when it equals MaxStreak and both requests are pending, fetch wins.
REQ-038 MEM_ARB_FAIRNESS_EN undefined: fixed data priority, no counter logic; fetch can starve under continuous d_req.

Verification
REQ-039 Reset low, then i_req=1, i_addr=0x00000005, mem_rdata=0xDEADBEEF -> i_gnt in cycle 1 with mem_addr=5 and mem_we=0; i_done in cycle 2 with i_rdata=0xDEADBEEF; i_rdata held afterward.
REQ-040 d_req=1, d_we=1, d_addr=0x00000210, d_wdata=0x12345678 -> one ACC cycle with mem_en=1, mem_we=1, mem_addr=0x010, mem_wdata=0x12345678; d_done next cycle; d_rdata unchanged.
REQ-041 i_req and d_req rise together (load) -> d_gnt first, i_gnt exactly 3 cycles later; gnt and done never overlap between requesters.
REQ-042 With MEM_ARB_FAIRNESS_EN and MaxStreak=4, d_req and i_req both held high continuously -> grant order D,D,D,D,I,D,D,D,D,I; without the macro, only D grants.
REQ-043 Reset pulled low during the ACC cycle of a load -> busy, mem_en and d_done drop immediately, d_rdata=0, and no d_done ever issues for that access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for a fetch and a data requester (IDLE/ACC/RESP).
// Optional fetch-fairness streak counter is built when MEM_ARB_FAIRNESS_EN is defined.
module mem_port_arbiter #(
   parameter int size        = 32,
   parameter int MemAddrBits = 9,
   parameter int MaxStreak   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_req,
   input  logic [size-1:0]        i_addr,
   output logic                   i_gnt,
   output logic                   i_done,
   output logic [size-1:0]        i_rdata,
   input  logic                   d_req,
   input  logic                   d_we,
   input  logic [size-1:0]        d_addr,
   input  logic [size-1:0]        d_wdata,
   output logic                   d_gnt,
   output logic                   d_done,
   output logic [size-1:0]        d_rdata,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [MemAddrBits-1:0] mem_addr,
   output logic [size-1:0]        mem_wdata,
   input  logic [size-1:0]        mem_rdata,
   output logic                   busy
);
   typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

   state_t                 state, state_nx;
   logic                   owner_d, owner_d_nx;   // 1 = data requester owns the access
   logic                   owner_we, owner_we_nx;
   logic                   data_wins;
   logic                   nx_acc, nx_resp;
   logic [MemAddrBits-1:0] mem_addr_nx;
   logic [size-1:0]        mem_wdata_nx;
   logic [size-1:0]        i_rdata_q, d_rdata_q;
   logic                   unused_inputs;

   assign unused_inputs = ^{i_addr[size-1:MemAddrBits], d_addr[size-1:MemAddrBits], MaxStreak[0]};

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int            SW         = $clog2(MaxStreak + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MaxStreak);

   logic [SW-1:0] streak;

   assign data_wins = d_req && !(i_req && streak == STREAK_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak <= '0;
      end else if (state == IDLE && (i_req || d_req)) begin
         if (!data_wins)
            streak <= '0;
         else if (i_req && streak != STREAK_MAX)
            streak <= streak + SW'(1);
      end
   end
`else
   assign data_wins = d_req;
`endif

   always_comb begin
      state_nx     = state;
      owner_d_nx   = owner_d;
      owner_we_nx  = owner_we;
      mem_addr_nx  = '0;
      mem_wdata_nx = '0;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               state_nx    = ACC;
               owner_d_nx  = data_wins;
               owner_we_nx = data_wins && d_we;
            end
         end
         ACC:     state_nx = RESP;
         default: state_nx = IDLE;
      endcase
      nx_acc  = (state_nx == ACC);
      nx_resp = (state_nx == RESP);
      // ACC is only entered from IDLE, so the requester inputs are the ones being latched
      if (nx_acc) begin
         mem_addr_nx = owner_d_nx ? d_addr[MemAddrBits-1:0] : i_addr[MemAddrBits-1:0];
         if (owner_d_nx)
            mem_wdata_nx = d_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner_d   <= 1'b0;
         owner_we  <= 1'b0;
         i_gnt     <= 1'b0;
         d_gnt     <= 1'b0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         owner_d   <= owner_d_nx;
         owner_we  <= owner_we_nx;
         i_gnt     <= nx_acc && !owner_d_nx;
         d_gnt     <= nx_acc && owner_d_nx;
         i_done    <= nx_resp && !owner_d_nx;
         d_done    <= nx_resp && owner_d_nx;
         mem_en    <= nx_acc;
         mem_we    <= nx_acc && owner_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         busy      <= (state_nx != IDLE);
      end
   end

   // Read data passes straight through during RESP and is held from then on
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (state == RESP) begin
         if (!owner_d)
            i_rdata_q <= mem_rdata;
         else if (!owner_we)
            d_rdata_q <= mem_rdata;
      end
   end

   assign i_rdata = (state == RESP && !owner_d) ? mem_rdata : i_rdata_q;
   assign d_rdata = (state == RESP && owner_d && !owner_we) ? mem_rdata : d_rdata_q;

endmodule
